// File: rtl/uba_vect_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uba_vect_arb
//  Description : UBA interrupt-acknowledge / vector arbiter. On a CPU vector
//                read for a PI level it grants the highest-priority eligible
//                device BR with a one-hot acknowledge. It then captures the
//                device's 16-bit vector into a 36-bit word, and falls back to
//                a timeout completion if no vector arrives. It also answers
//                the CPU "who are you" poll with a registered match bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uba_vect_arb #(
  parameter int TIMEOUT = 64            // GRANT cycles before forced completion (>=2)
) (
  input  logic          clk,
  input  logic          rst,
  // WRU poll
  input  logic          wruREAD,
  input  logic [0:2]    wruPI,
  output logic          wruRESP,
  // CPU vector read
  input  logic          vectREAD,
  input  logic [0:2]    vectPI,
  output logic          vectDONE,
  output logic [0:35]   vectDATA,
  output logic          vectNONE,
  output logic          vectTMO,
  // PI assignment of the BR pairs
  input  logic [0:2]    statPIH,
  input  logic [0:2]    statPIL,
  // Device side
  input  logic [7:4]    devINTR,
  output logic [7:4]    devACKO,
  input  logic          devVECTV,
  input  logic [15:0]   devVECT
);

  localparam int              CNT_W       = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  // ST_NONE is a one-cycle passive-release step so a read with no requester
  // completes with the same two-cycle latency as the bus would take to settle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NONE  = 2'd1,
    ST_GRANT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        ack_q, ack_d;
  logic [35:0]       data_q, data_d;
  logic              none_q, none_d;
  logic              tmo_q, tmo_d;
  logic              wru_q, wru_d;

  logic [3:0]        w_vect_cand;
  logic [3:0]        w_vect_win;
  logic [3:0]        w_wru_cand;

  // Candidate BRs at a level: eligible through its PI assignment and requesting.
  // Bit 3..0 map to BR7..BR4. Level 0 never matches anything.
  function automatic logic [3:0] cand_f(input logic [2:0] lvl,
                                        input logic [2:0] pih,
                                        input logic [2:0] pil,
                                        input logic [3:0] intr);
    logic [3:0] elig;
    elig = 4'b0000;
    if (lvl != 3'd0) begin
      elig[3] = (pih == lvl);
      elig[2] = (pih == lvl);
      elig[1] = (pil == lvl);
      elig[0] = (pil == lvl);
    end
    return elig & intr;
  endfunction

  // Fixed priority BR7 > BR6 > BR5 > BR4, one-hot result.
  function automatic logic [3:0] pick_f(input logic [3:0] cand);
    logic [3:0] win;
    win = 4'b0000;
    if (cand[3])      win = 4'b1000;
    else if (cand[2]) win = 4'b0100;
    else if (cand[1]) win = 4'b0010;
    else if (cand[0]) win = 4'b0001;
    return win;
  endfunction

  assign w_vect_cand = cand_f(vectPI, statPIH, statPIL, devINTR);
  assign w_vect_win  = pick_f(w_vect_cand);
  assign w_wru_cand  = cand_f(wruPI, statPIH, statPIL, devINTR);

  // Vector FSM next-state and next-value logic; everything holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    data_d  = data_q;
    none_d  = none_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (vectREAD) begin
          // Accepting a read clears the previous result.
          data_d = 36'd0;
          none_d = 1'b0;
          tmo_d  = 1'b0;
          if (w_vect_win == 4'b0000) begin
            state_d = ST_NONE;
          end else begin
            ack_d   = w_vect_win;
            cnt_d   = '0;
            state_d = ST_GRANT;
          end
        end
      end
      ST_NONE: begin
        none_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_GRANT: begin
        // The vector takes precedence over a timeout on the same cycle.
        if (devVECTV) begin
          data_d  = {20'd0, devVECT};
          ack_d   = 4'b0000;
          state_d = ST_DONE;
        end else if (cnt_q == c_cnt_last) begin
          data_d  = 36'd0;
          tmo_d   = 1'b1;
          ack_d   = 4'b0000;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        ack_d   = 4'b0000;
        state_d = ST_IDLE;
      end
    endcase
  end

  // WRU answer is purely a registered lookup, independent of the vector FSM.
  always_comb begin
    wru_d = wruREAD & (|w_wru_cand);
  end

  // State and output registers; reset drops the acknowledge immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 4'b0000;
      data_q  <= 36'd0;
      none_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wru_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      none_q  <= none_d;
      tmo_q   <= tmo_d;
      wru_q   <= wru_d;
    end
  end

  assign vectDONE = (state_q == ST_DONE);
  assign vectDATA = data_q;
  assign vectNONE = none_q;
  assign vectTMO  = tmo_q;
  assign devACKO  = ack_q;
  assign wruRESP  = wru_q;

endmodule
`default_nettype wire

// File: tb/tb_uba_vect_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uba_vect_arb
//  Description : Directed self-checking bench for uba_vect_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uba_vect_arb;

  logic          clk;
  logic          rst;
  logic          wruREAD;
  logic [0:2]    wruPI;
  logic          wruRESP;
  logic          vectREAD;
  logic [0:2]    vectPI;
  logic          vectDONE;
  logic [0:35]   vectDATA;
  logic          vectNONE;
  logic          vectTMO;
  logic [0:2]    statPIH;
  logic [0:2]    statPIL;
  logic [7:4]    devINTR;
  logic [7:4]    devACKO;
  logic          devVECTV;
  logic [15:0]   devVECT;

  int checks;
  int failures;

  uba_vect_arb #(.TIMEOUT(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .wruREAD  (wruREAD),
    .wruPI    (wruPI),
    .wruRESP  (wruRESP),
    .vectREAD (vectREAD),
    .vectPI   (vectPI),
    .vectDONE (vectDONE),
    .vectDATA (vectDATA),
    .vectNONE (vectNONE),
    .vectTMO  (vectTMO),
    .statPIH  (statPIH),
    .statPIL  (statPIL),
    .devINTR  (devINTR),
    .devACKO  (devACKO),
    .devVECTV (devVECTV),
    .devVECT  (devVECT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hard stop in case something wedges the sequence.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  acks;
    logic saw_done;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wruREAD  = 1'b0;
    wruPI    = 3'd0;
    vectREAD = 1'b0;
    vectPI   = 3'd0;
    statPIH  = 3'd0;
    statPIL  = 3'd0;
    devINTR  = 4'b0000;
    devVECTV = 1'b0;
    devVECT  = 16'd0;

    // ---- reset state
    cyc(); cyc();
    chk("rst_ack",  devACKO,  4'b0000);
    chk("rst_done", vectDONE, 1'b0);
    chk("rst_data", vectDATA, 36'd0);
    chk("rst_none", vectNONE, 1'b0);
    chk("rst_tmo",  vectTMO,  1'b0);
    chk("rst_wru",  wruRESP,  1'b0);
    rst = 1'b0;
    cyc();

    // ---- 1: BR7 at PIH=3, vector 0o260 two cycles after ack
    devINTR = 4'b1000; statPIH = 3'd3; statPIL = 3'd0;
    vectPI = 3'd3; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    chk("t1_ack", devACKO, 4'b1000);
    chk("t1_nodone", vectDONE, 1'b0);
    cyc(); cyc();
    devVECTV = 1'b1; devVECT = 16'o260;
    cyc(); devVECTV = 1'b0;
    chk("t1_done", vectDONE, 1'b1);
    chk("t1_data", vectDATA, 36'o260);
    chk("t1_tmo",  vectTMO,  1'b0);
    chk("t1_ackoff", devACKO, 4'b0000);
    cyc();
    chk("t1_done_pulse", vectDONE, 1'b0);
    chk("t1_data_hold", vectDATA, 36'o260);

    // ---- 2: all requesting at level 4 -> BR7; winner frozen when devINTR drops
    devINTR = 4'b1111; statPIH = 3'd4; statPIL = 3'd4;
    vectPI = 3'd4; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    chk("t2_ack_br7", devACKO, 4'b1000);
    chk("t2_data_clr", vectDATA, 36'd0);
    devINTR = 4'b0000;
    cyc();
    chk("t2_frozen", devACKO, 4'b1000);
    devVECTV = 1'b1; devVECT = 16'hABCD;
    cyc(); devVECTV = 1'b0;
    chk("t2_done", vectDONE, 1'b1);
    chk("t2_data", vectDATA, 36'h0_0000_ABCD);
    cyc();
    // BR5 wins when only BR5/BR4 request; a read during GRANT is ignored
    devINTR = 4'b0011; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    chk("t2_ack_br5", devACKO, 4'b0010);
    devINTR = 4'b1000; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    chk("t2_read_ignored", devACKO, 4'b0010);
    devVECTV = 1'b1; devVECT = 16'o777;
    cyc(); devVECTV = 1'b0;
    chk("t2b_done", vectDONE, 1'b1);
    chk("t2b_data", vectDATA, 36'o777);
    cyc();
    chk("t2b_idle_ack", devACKO, 4'b0000);

    // ---- 3: BR4 at PIL=2, read at level 5 -> passive release
    devINTR = 4'b0001; statPIH = 3'd0; statPIL = 3'd2;
    vectPI = 3'd5; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    chk("t3_noack", devACKO, 4'b0000);
    chk("t3_done_early", vectDONE, 1'b0);
    cyc();
    chk("t3_done", vectDONE, 1'b1);
    chk("t3_none", vectNONE, 1'b1);
    chk("t3_data", vectDATA, 36'd0);
    cyc();
    chk("t3_none_hold", vectNONE, 1'b1);
    chk("t3_done_pulse", vectDONE, 1'b0);

    // ---- 4: BR6 granted, no vector -> 64 cycles of ack, then timeout
    devINTR = 4'b0100; statPIH = 3'd6; statPIL = 3'd0;
    vectPI = 3'd6; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    acks = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (vectDONE) begin
        saw_done = 1'b1;
        break;
      end
      if (devACKO == 4'b0100) acks++;
      cyc();
    end
    chk("t4_ack_cycles", acks, 64);
    chk("t4_done", saw_done, 1'b1);
    chk("t4_tmo", vectTMO, 1'b1);
    chk("t4_data", vectDATA, 36'd0);
    chk("t4_none_clr", vectNONE, 1'b0);
    chk("t4_ackoff", devACKO, 4'b0000);
    cyc();
    // vector arriving on the timeout cycle wins
    vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    for (int i = 0; i < 63; i++) cyc();
    chk("t4b_ack_still", devACKO, 4'b0100);
    devVECTV = 1'b1; devVECT = 16'h1234;
    cyc(); devVECTV = 1'b0;
    chk("t4b_done", vectDONE, 1'b1);
    chk("t4b_tmo", vectTMO, 1'b0);
    chk("t4b_data", vectDATA, 36'h0_0000_1234);
    cyc();

    // ---- 5: WRU poll, idle and during an active GRANT
    devINTR = 4'b0011; statPIH = 3'd0; statPIL = 3'd2;
    wruPI = 3'd2; wruREAD = 1'b1;
    cyc(); wruREAD = 1'b0;
    chk("t5_wru_hit", wruRESP, 1'b1);
    cyc();
    chk("t5_wru_noread", wruRESP, 1'b0);
    wruPI = 3'd1; wruREAD = 1'b1;
    cyc(); wruREAD = 1'b0;
    chk("t5_wru_miss", wruRESP, 1'b0);
    wruPI = 3'd0; wruREAD = 1'b1;
    cyc(); wruREAD = 1'b0;
    chk("t5_wru_lvl0", wruRESP, 1'b0);
    vectPI = 3'd2; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    chk("t5_ack", devACKO, 4'b0010);
    wruPI = 3'd2; wruREAD = 1'b1;
    cyc(); wruREAD = 1'b0;
    chk("t5_wru_hit_grant", wruRESP, 1'b1);
    wruPI = 3'd1; wruREAD = 1'b1;
    cyc(); wruREAD = 1'b0;
    chk("t5_wru_miss_grant", wruRESP, 1'b0);

    // ---- 6: reset mid-GRANT drops ack at once, no completion follows
    chk("t6_pre_ack", devACKO, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_ack_async", devACKO, 4'b0000);
    cyc();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vectDONE) saw_done = 1'b1;
      cyc();
    end
    chk("t6_no_done", saw_done, 1'b0);
    vectPI = 3'd2; vectREAD = 1'b1;
    cyc(); vectREAD = 1'b0;
    chk("t6_ack_again", devACKO, 4'b0010);
    devVECTV = 1'b1; devVECT = 16'h00FF;
    cyc(); devVECTV = 1'b0;
    chk("t6_done", vectDONE, 1'b1);
    chk("t6_data", vectDATA, 36'h0_0000_00FF);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
